perf_counter_bank: RTL and testbench

Parametrised bank of NUM_CH event counters that replaces the fixed per-event performance counters and their hard-wired memory-mapped readout in the pipelined LC-3b datapath. Each channel supports:
- cycle counting or per-event counting, with a programmable run-length threshold (for example, counting cache misses rather than miss cycles);
- wrap or saturate on overflow, with sticky overflow flags;
- reads, writes and clears through a one-cycle MMIO port that the MEM stage muxes in ahead of the data cache.

---
 rtl/perf_pkg.sv | 49 ++++
 rtl/perf_channel.sv | 118 +++++++++++
 rtl/perf_counter_bank.sv | 166 ++++++++++++++++
 tb/tb_perf_counter_bank.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: register map layout,
// CFG/GCTL field positions and reset constants.
package perf_pkg;

    // Register index offsets inside the MMIO window
    localparam int IDX_COUNT = 0;

    function automatic int idx_cfg(input int num_ch);
        return num_ch;
    endfunction

    function automatic int idx_gctl(input int num_ch);
        return 2 * num_ch;
    endfunction

    function automatic int idx_ovf(input int num_ch);
        return 2 * num_ch + 1;
    endfunction

    // The window spans the next power-of-two number of 16-bit registers that
    // covers every mapped index; the spare slots read as zero.
    function automatic int win_regs(input int num_ch);
        return 1 << $clog2(2 * num_ch + 2);
    endfunction

    // CFG[ch] field positions
    localparam int CFG_EN_BIT   = 0;
    localparam int CFG_MODE_BIT = 1;
    localparam int CFG_THR_LSB  = 2;

    // GCTL bit positions
    localparam int GCTL_GEN_BIT = 0;
    localparam int GCTL_SAT_BIT = 1;
    localparam int GCTL_CLR_BIT = 2;

    // Reset values: channel enabled, cycle mode, threshold 1; bank enabled, wrap
    localparam logic [15:0] CFG_RESET  = 16'h0005;
    localparam logic [15:0] GCTL_RESET = 16'h0001;

    // Register class selected by the decoded index
    typedef enum logic [2:0] {
        REG_NONE,
        REG_COUNT,
        REG_CFG,
        REG_GCTL,
        REG_OVF
    } reg_kind_e;

endpackage

// File: rtl/perf_channel.sv
// One counter channel: run-length tracking, threshold qualification,
// wrap/saturate counting, sticky overflow flag and the channel's CFG register.
module perf_channel
    import perf_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int THRESH_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_event,
    input  logic             i_global_en,
    input  logic             i_saturate,
    input  logic             i_clear_all,
    input  logic             i_cnt_we,
    input  logic             i_cfg_we,
    input  logic             i_ovf_clr,
    input  logic [15:0]      i_wdata,
    output logic [CNT_W-1:0] o_count,
    output logic [15:0]      o_cfg,
    output logic             o_ovf
);

    logic                r_en;
    logic                r_mode;
    logic [THRESH_W-1:0] r_thr;
    logic [THRESH_W-1:0] r_run;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;

    logic                w_active;
    logic [THRESH_W-1:0] w_thr_eff;
    logic [THRESH_W:0]   w_run_next;
    logic                w_run_hit;
    logic                w_inc;
    logic                w_at_max;
    logic                w_unused_wdata;

    assign w_active  = r_en & i_global_en;
    // A programmed threshold of zero behaves like one
    assign w_thr_eff = (r_thr == '0) ? THRESH_W'(1) : r_thr;
    // Run length including the current cycle; one bit wider so it cannot wrap
    assign w_run_next = {1'b0, r_run} + (THRESH_W + 1)'(1);
    assign w_run_hit  = r_mode ? (w_run_next == {1'b0, w_thr_eff})
                               : (w_run_next >= {1'b0, w_thr_eff});
    // clear_all and a COUNT write both override the increment for this edge
    assign w_inc      = w_active & i_event & w_run_hit & ~i_clear_all & ~i_cnt_we;
    assign w_at_max   = &r_count;

    // Upper write-data bits are not used when the fields are narrower than 16
    assign w_unused_wdata = ^i_wdata;

    // CFG register: enable, event mode and run-length threshold
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en   <= CFG_RESET[CFG_EN_BIT];
            r_mode <= CFG_RESET[CFG_MODE_BIT];
            r_thr  <= CFG_RESET[CFG_THR_LSB +: THRESH_W];
        end else if (i_cfg_we) begin
            r_en   <= i_wdata[CFG_EN_BIT];
            r_mode <= i_wdata[CFG_MODE_BIT];
            r_thr  <= i_wdata[CFG_THR_LSB +: THRESH_W];
        end
    end

    // Saturating run length of consecutive active event cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= '0;
        end else if (i_clear_all) begin
            r_run <= '0;
        end else if (w_active && i_event) begin
            if (r_run != '1) begin
                r_run <= r_run + THRESH_W'(1);
            end
        end else begin
            r_run <= '0;
        end
    end

    // Event count: clear_all, then MMIO load, then qualified increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear_all) begin
            r_count <= '0;
        end else if (i_cnt_we) begin
            r_count <= i_wdata[CNT_W-1:0];
        end else if (w_inc && !(w_at_max && i_saturate)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Sticky overflow flag; a new overflow wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= (w_inc & w_at_max) | (r_ovf & ~i_ovf_clr);
        end
    end

    // CFG readback image, zero-extended to 16 bits
    // NOTE: the default assignment first keeps every bit driven on every
    // path, so no latch is inferred.
    always_comb begin
        o_cfg                            = '0;
        o_cfg[CFG_EN_BIT]                = r_en;
        o_cfg[CFG_MODE_BIT]              = r_mode;
        o_cfg[CFG_THR_LSB +: THRESH_W]   = r_thr;
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH performance counters behind a one-cycle MMIO port. Holds
// the address decode, global control, overflow aggregation and read mux.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int          NUM_CH    = 9,
    parameter int          CNT_W     = 16,
    parameter int          THRESH_W  = 4,
    parameter logic [15:0] BASE_ADDR = 16'hFFC0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] events,
    input  logic              mmio_req,
    input  logic              mmio_we,
    input  logic [15:0]       mmio_addr,
    input  logic [15:0]       mmio_wdata,
    output logic              mmio_hit,
    output logic              mmio_resp,
    output logic [15:0]       mmio_rdata,
    output logic              ovf_irq
);

    localparam int               WIN       = win_regs(NUM_CH);
    localparam int               IDX_W     = $clog2(WIN);
    localparam logic [16:0]      WIN_BYTES = 17'(2 * WIN);
    localparam logic [IDX_W-1:0] IDX_CFG   = IDX_W'(idx_cfg(NUM_CH));
    localparam logic [IDX_W-1:0] IDX_GCTL  = IDX_W'(idx_gctl(NUM_CH));
    localparam logic [IDX_W-1:0] IDX_OVF   = IDX_W'(idx_ovf(NUM_CH));

    logic              r_global_en;
    logic              r_saturate;
    logic              r_resp;
    logic [15:0]       r_rdata;

    logic [16:0]       w_offset;
    logic [IDX_W-1:0]  w_idx;
    reg_kind_e         w_kind;
    logic              w_access;
    logic              w_wr;
    logic              w_gctl_wr;
    logic              w_ovf_wr;
    logic              w_clear_all;
    logic [15:0]       w_rdata;
    logic              w_unused_offset;

    logic [NUM_CH-1:0] w_cnt_we;
    logic [NUM_CH-1:0] w_cfg_we;
    logic [NUM_CH-1:0] w_ovf_clr;
    logic [NUM_CH-1:0] w_ovf;
    logic [CNT_W-1:0]  w_count [NUM_CH];
    logic [15:0]       w_cfg   [NUM_CH];

    // 17-bit difference: addresses below the base wrap to a huge offset and miss
    assign w_offset = {1'b0, mmio_addr} - {1'b0, BASE_ADDR};
    assign mmio_hit = (w_offset < WIN_BYTES);
    // Byte-address bit 0 is ignored
    assign w_idx    = w_offset[IDX_W:1];
    assign w_unused_offset = ^{w_offset[16:IDX_W+1], w_offset[0]};

    assign w_access    = mmio_req & mmio_hit;
    assign w_wr        = w_access & mmio_we;
    assign w_gctl_wr   = w_wr & (w_kind == REG_GCTL);
    assign w_ovf_wr    = w_wr & (w_kind == REG_OVF);
    // clear_all is a strobe only; it is never stored and so reads back as 0
    assign w_clear_all = w_gctl_wr & mmio_wdata[GCTL_CLR_BIT];

    // Classify the window index into a register class
    always_comb begin
        w_kind = REG_NONE;
        if (w_idx < IDX_CFG) begin
            w_kind = REG_COUNT;
        end else if (w_idx < IDX_GCTL) begin
            w_kind = REG_CFG;
        end else if (w_idx == IDX_GCTL) begin
            w_kind = REG_GCTL;
        end else if (w_idx == IDX_OVF) begin
            w_kind = REG_OVF;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_cnt_we[c]  = w_wr & (w_kind == REG_COUNT) &
                              (w_idx == IDX_W'(IDX_COUNT + c));
        assign w_cfg_we[c]  = w_wr & (w_kind == REG_CFG) &
                              (w_idx == IDX_W'(idx_cfg(NUM_CH) + c));
        assign w_ovf_clr[c] = w_ovf_wr & mmio_wdata[c];

        perf_channel #(
            .CNT_W    (CNT_W),
            .THRESH_W (THRESH_W)
        ) u_channel (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_event     (events[c]),
            .i_global_en (r_global_en),
            .i_saturate  (r_saturate),
            .i_clear_all (w_clear_all),
            .i_cnt_we    (w_cnt_we[c]),
            .i_cfg_we    (w_cfg_we[c]),
            .i_ovf_clr   (w_ovf_clr[c]),
            .i_wdata     (mmio_wdata),
            .o_count     (w_count[c]),
            .o_cfg       (w_cfg[c]),
            .o_ovf       (w_ovf[c])
        );
    end

    // Read mux over the pre-edge register values; unmapped slots read 0
    always_comb begin
        w_rdata = '0;
        case (w_kind)
            REG_COUNT: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_idx == IDX_W'(IDX_COUNT + c)) begin
                        w_rdata = 16'(w_count[c]);
                    end
                end
            end
            REG_CFG: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_idx == IDX_W'(idx_cfg(NUM_CH) + c)) begin
                        w_rdata = w_cfg[c];
                    end
                end
            end
            REG_GCTL: begin
                w_rdata[GCTL_GEN_BIT] = r_global_en;
                w_rdata[GCTL_SAT_BIT] = r_saturate;
            end
            REG_OVF: begin
                w_rdata = 16'(w_ovf);
            end
            default: begin
                w_rdata = '0;
            end
        endcase
    end

    // Global control: bank enable and overflow policy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_global_en <= GCTL_RESET[GCTL_GEN_BIT];
            r_saturate  <= GCTL_RESET[GCTL_SAT_BIT];
        end else if (w_gctl_wr) begin
            r_global_en <= mmio_wdata[GCTL_GEN_BIT];
            r_saturate  <= mmio_wdata[GCTL_SAT_BIT];
        end
    end

    // One-cycle response; read data is captured only for read hits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_resp  <= w_access;
            r_rdata <= (w_access && !mmio_we) ? w_rdata : '0;
        end
    end

    assign mmio_resp  = r_resp;
    assign mmio_rdata = r_rdata;
    assign ovf_irq    = |w_ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: directed scenarios plus a
// randomized phase, all checked against a cycle-level behavioural model.
module tb_perf_counter_bank;

    localparam int          NUM_CH    = 9;
    localparam int          CNT_W     = 16;
    localparam int          THRESH_W  = 4;
    localparam logic [15:0] BASE      = 16'hFFC0;
    localparam int          WIN_BYTES = 64;
    localparam int          I_GCTL    = 2 * NUM_CH;
    localparam int          I_OVF     = 2 * NUM_CH + 1;
    localparam int          MAXV      = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] events;
    logic              mmio_req;
    logic              mmio_we;
    logic [15:0]       mmio_addr;
    logic [15:0]       mmio_wdata;
    logic              mmio_hit;
    logic              mmio_resp;
    logic [15:0]       mmio_rdata;
    logic              ovf_irq;

    perf_counter_bank #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .THRESH_W  (THRESH_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .events     (events),
        .mmio_req   (mmio_req),
        .mmio_we    (mmio_we),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_hit   (mmio_hit),
        .mmio_resp  (mmio_resp),
        .mmio_rdata (mmio_rdata),
        .ovf_irq    (ovf_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    int m_cnt  [NUM_CH];
    int m_run  [NUM_CH];
    bit m_en   [NUM_CH];
    bit m_mode [NUM_CH];
    int m_thr  [NUM_CH];
    bit m_ovf  [NUM_CH];
    bit m_gen;
    bit m_sat;

    bit exp_resp;
    bit exp_is_read;
    int exp_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_run[c] = 0; m_en[c] = 1'b1; m_mode[c] = 1'b0;
            m_thr[c] = 1; m_ovf[c] = 1'b0;
        end
        m_gen = 1'b1;
        m_sat = 1'b0;
    endfunction

    function automatic int addr_index(input logic [15:0] a);
        int off;
        off = int'(a) - int'(BASE);
        if (off < 0 || off >= WIN_BYTES) return -1;
        return off / 2;
    endfunction

    function automatic int model_read(input int idx);
        int v;
        if (idx < NUM_CH) return m_cnt[idx];
        if (idx < 2 * NUM_CH)
            return (m_thr[idx-NUM_CH] << 2) | (int'(m_mode[idx-NUM_CH]) << 1) | int'(m_en[idx-NUM_CH]);
        if (idx == I_GCTL) return (int'(m_sat) << 1) | int'(m_gen);
        if (idx == I_OVF) begin
            v = 0;
            for (int c = 0; c < NUM_CH; c++) if (m_ovf[c]) v += (1 << c);
            return v;
        end
        return 0;
    endfunction

    function automatic bit model_irq();
        bit r;
        r = 1'b0;
        for (int c = 0; c < NUM_CH; c++) r |= m_ovf[c];
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    function automatic void model_edge();
        int idx, t;
        bit wr, clr, fire, set;
        idx         = mmio_req ? addr_index(mmio_addr) : -1;
        exp_resp    = (idx >= 0);
        exp_is_read = exp_resp && !mmio_we;
        exp_rdata   = exp_is_read ? model_read(idx) : 0;
        wr          = exp_resp && mmio_we;
        clr         = wr && idx == I_GCTL && mmio_wdata[2];
        for (int c = 0; c < NUM_CH; c++) begin
            t   = (m_thr[c] == 0) ? 1 : m_thr[c];
            set = 1'b0;
            if (m_en[c] && m_gen && events[c]) begin
                m_run[c]++;
                fire = m_mode[c] ? (m_run[c] == t) : (m_run[c] >= t);
            end else begin
                m_run[c] = 0;
                fire     = 1'b0;
            end
            if (clr) begin
                m_cnt[c] = 0;
                m_run[c] = 0;
            end else if (wr && idx == c) begin
                m_cnt[c] = int'(mmio_wdata) & MAXV;
            end else if (fire) begin
                if (m_cnt[c] == MAXV) begin
                    m_cnt[c] = m_sat ? MAXV : 0;
                    set      = 1'b1;
                end else begin
                    m_cnt[c]++;
                end
            end
            if (wr && idx == I_OVF && mmio_wdata[c]) m_ovf[c] = 1'b0;
            if (set) m_ovf[c] = 1'b1;
            if (wr && idx == NUM_CH + c) begin
                m_en[c]   = mmio_wdata[0];
                m_mode[c] = mmio_wdata[1];
                m_thr[c]  = int'(mmio_wdata[5:2]);
            end
        end
        if (wr && idx == I_GCTL) begin
            m_gen = mmio_wdata[0];
            m_sat = mmio_wdata[1];
        end
    endfunction

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        mmio_req = 1'b0;
        mmio_we  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input int idx, input logic [15:0] d);
        mmio_req   = 1'b1;
        mmio_we    = 1'b1;
        mmio_addr  = BASE + 16'(2 * idx);
        mmio_wdata = d;
        cycle();
    endtask

    task automatic rd(input int idx, output logic [15:0] d);
        mmio_req  = 1'b1;
        mmio_we   = 1'b0;
        mmio_addr = BASE + 16'(2 * idx);
        cycle();
        d = mmio_rdata;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        #3;
        n_checks++; if (mmio_resp !== 1'b0) $display("FAIL rst_resp: got %b exp 0", mmio_resp); else n_pass++;
        n_checks++; if (mmio_rdata !== 16'h0) $display("FAIL rst_rdata: got %h exp 0000", mmio_rdata); else n_pass++;
        n_checks++; if (ovf_irq !== 1'b0) $display("FAIL rst_irq: got %b exp 0", ovf_irq); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        events = '1;
        idle(4);
        rd(0, d);
        n_checks++; if (mmio_resp !== 1'b1) $display("FAIL pre_reset_resp: got %b exp 1", mmio_resp); else n_pass++;
        n_checks++; if (d !== 16'(exp_rdata)) $display("FAIL pre_reset_count: got %h exp %h", d, 16'(exp_rdata)); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (mmio_resp !== 1'b0) $display("FAIL midrst_resp: got %b exp 0", mmio_resp); else n_pass++;
        n_checks++; if (mmio_rdata !== 16'h0) $display("FAIL midrst_rdata: got %h exp 0000", mmio_rdata); else n_pass++;
        n_checks++; if (ovf_irq !== 1'b0) $display("FAIL midrst_irq: got %b exp 0", ovf_irq); else n_pass++;
        model_reset();
        events = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(NUM_CH, d);
        n_checks++; if (d !== 16'h0005) $display("FAIL cfg0_reset: got %h exp 0005", d); else n_pass++;
        rd(I_GCTL, d);
        n_checks++; if (d !== 16'h0001) $display("FAIL gctl_reset: got %h exp 0001", d); else n_pass++;
        rd(0, d);
        n_checks++; if (d !== 16'h0000) $display("FAIL count0_reset: got %h exp 0000", d); else n_pass++;
    endtask

    task automatic test_cycle_mode();
        logic [15:0] d;
        events = NUM_CH'(1);
        idle(7);
        events = '0;
        rd(0, d);
        n_checks++; if (d !== 16'd7) $display("FAIL cyc_t1: got %h exp 0007", d); else n_pass++;
        wr(NUM_CH + 1, 16'h000D);
        events = NUM_CH'(2);
        idle(7);
        events = '0;
        rd(1, d);
        n_checks++; if (d !== 16'd5) $display("FAIL cyc_t3: got %h exp 0005", d); else n_pass++;
    endtask

    task automatic test_event_mode();
        logic [15:0] d;
        wr(NUM_CH + 3, 16'h000B);
        events = NUM_CH'(8); idle(1);
        events = '0;         idle(1);
        events = NUM_CH'(8); idle(2);
        events = '0;         idle(1);
        events = NUM_CH'(8); idle(5);
        events = '0;
        rd(3, d);
        n_checks++; if (d !== 16'd2) $display("FAIL evt_t2: got %h exp 0002", d); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        wr(2, 16'hFFFE);
        events = NUM_CH'(4); idle(3); events = '0;
        rd(2, d);
        n_checks++; if (d !== 16'h0001) $display("FAIL wrap_count: got %h exp 0001", d); else n_pass++;
        n_checks++; if (ovf_irq !== 1'b1) $display("FAIL wrap_irq: got %b exp 1", ovf_irq); else n_pass++;
        rd(I_OVF, d);
        n_checks++; if (d !== 16'h0004) $display("FAIL wrap_ovf: got %h exp 0004", d); else n_pass++;
        wr(I_OVF, 16'h0004);
        n_checks++; if (ovf_irq !== 1'b0) $display("FAIL ovf_clr_irq: got %b exp 0", ovf_irq); else n_pass++;
        rd(I_OVF, d);
        n_checks++; if (d !== 16'h0000) $display("FAIL ovf_clr: got %h exp 0000", d); else n_pass++;
        wr(I_GCTL, 16'h0003);
        wr(2, 16'hFFFE);
        events = NUM_CH'(4); idle(3); events = '0;
        rd(2, d);
        n_checks++; if (d !== 16'hFFFF) $display("FAIL sat_count: got %h exp ffff", d); else n_pass++;
        n_checks++; if (ovf_irq !== 1'b1) $display("FAIL sat_irq: got %b exp 1", ovf_irq); else n_pass++;
        wr(I_OVF, 16'h0004);
        wr(I_GCTL, 16'h0001);
    endtask

    task automatic test_write_vs_inc();
        logic [15:0] d;
        events = NUM_CH'(1);
        wr(0, 16'h0010);
        rd(0, d);
        n_checks++; if (d !== 16'h0010) $display("FAIL wr_beats_inc: got %h exp 0010", d); else n_pass++;
        events = '0;
        rd(0, d);
        n_checks++; if (d !== 16'h0011) $display("FAIL rd_after_inc: got %h exp 0011", d); else n_pass++;
    endtask

    task automatic test_global();
        logic [15:0] d;
        wr(I_GCTL, 16'h0000);
        events = '1; idle(5); events = '0;
        rd(0, d);
        n_checks++; if (d !== 16'h0011) $display("FAIL frozen0: got %h exp 0011", d); else n_pass++;
        rd(1, d);
        n_checks++; if (d !== 16'h0005) $display("FAIL frozen1: got %h exp 0005", d); else n_pass++;
        rd(3, d);
        n_checks++; if (d !== 16'h0002) $display("FAIL frozen3: got %h exp 0002", d); else n_pass++;
        wr(I_GCTL, 16'h0001);
        wr(I_GCTL, 16'h0005);
        n_checks++; if (mmio_resp !== 1'b1) $display("FAIL clear_resp: got %b exp 1", mmio_resp); else n_pass++;
        idle(1);
        n_checks++; if (mmio_resp !== 1'b0) $display("FAIL clear_resp_once: got %b exp 0", mmio_resp); else n_pass++;
        for (int c = 0; c < NUM_CH; c++) begin
            rd(c, d);
            n_checks++; if (d !== 16'h0000) $display("FAIL clear_count%0d: got %h exp 0000", c, d); else n_pass++;
        end
        rd(I_GCTL, d);
        n_checks++; if (d !== 16'h0001) $display("FAIL gctl_after_clear: got %h exp 0001", d); else n_pass++;
    endtask

    task automatic test_decode();
        logic [15:0] d;
        logic [15:0] miss_addrs [3];
        miss_addrs = '{16'hFFBE, 16'h0000, 16'h7FC0};
        for (int i = 0; i < 3; i++) begin
            mmio_req = 1'b1; mmio_we = 1'b0; mmio_addr = miss_addrs[i];
            #1;
            n_checks++; if (mmio_hit !== 1'b0) $display("FAIL miss_hit %h: got %b exp 0", miss_addrs[i], mmio_hit); else n_pass++;
            cycle();
            n_checks++; if (mmio_resp !== 1'b0) $display("FAIL miss_resp %h: got %b exp 0", miss_addrs[i], mmio_resp); else n_pass++;
        end
        mmio_req = 1'b1; mmio_we = 1'b0; mmio_addr = BASE + 16'd50;
        #1;
        n_checks++; if (mmio_hit !== 1'b1) $display("FAIL unmapped_hit: got %b exp 1", mmio_hit); else n_pass++;
        cycle();
        n_checks++; if (mmio_resp !== 1'b1) $display("FAIL unmapped_resp: got %b exp 1", mmio_resp); else n_pass++;
        n_checks++; if (mmio_rdata !== 16'h0000) $display("FAIL unmapped_rd: got %h exp 0000", mmio_rdata); else n_pass++;
        wr(25, 16'hFFFF);
        rd(25, d);
        n_checks++; if (d !== 16'h0000) $display("FAIL unmapped_wr: got %h exp 0000", d); else n_pass++;
        mmio_req = 1'b1; mmio_we = 1'b0; mmio_addr = BASE + 16'(2 * I_GCTL + 1);
        cycle();
        n_checks++; if (mmio_rdata !== 16'h0001) $display("FAIL odd_addr: got %h exp 0001", mmio_rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        events = NUM_CH'(15);
        for (int i = 0; i < 8; i++) begin
            mmio_req = 1'b1; mmio_we = 1'b0; mmio_addr = BASE + 16'(2 * (i % 4));
            cycle();
            n_checks++; if (mmio_resp !== 1'b1) $display("FAIL b2b_resp%0d: got %b exp 1", i, mmio_resp); else n_pass++;
            n_checks++; if (mmio_rdata !== 16'(exp_rdata)) $display("FAIL b2b_data%0d: got %h exp %h", i, mmio_rdata, 16'(exp_rdata)); else n_pass++;
        end
        events = '0;
    endtask

    task automatic test_random();
        int op;
        for (int c = 0; c < NUM_CH; c++)
            wr(NUM_CH + c, 16'({$urandom_range(0, 15), 1'($urandom), 1'b1}));
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NUM_CH; c++) events[c] = ($urandom_range(0, 3) != 0);
            op = $urandom_range(0, 9);
            mmio_req = (op <= 7);
            mmio_we  = (op >= 5);
            if (op <= 4) begin
                mmio_addr = BASE + 16'(2 * $urandom_range(0, I_OVF + 2));
            end else if (op == 5) begin
                mmio_addr  = BASE + 16'(2 * $urandom_range(0, NUM_CH - 1));
                mmio_wdata = ($urandom_range(0, 1) == 1) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
            end else if (op == 6) begin
                mmio_addr  = BASE + 16'(2 * I_OVF);
                mmio_wdata = 16'($urandom);
            end else if (op == 7) begin
                if ($urandom_range(0, 1) == 1) begin
                    mmio_addr  = BASE + 16'(2 * (NUM_CH + $urandom_range(0, NUM_CH - 1)));
                    mmio_wdata = 16'({$urandom_range(0, 15), 1'($urandom), ($urandom_range(0, 5) != 0)});
                end else begin
                    mmio_addr  = BASE + 16'(2 * I_GCTL);
                    mmio_wdata = 16'({($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 7) != 0)});
                end
            end
            cycle();
            n_checks++; if (mmio_resp !== exp_resp) $display("FAIL rnd_resp%0d: got %b exp %b", i, mmio_resp, exp_resp); else n_pass++;
            if (exp_is_read) begin
                n_checks++; if (mmio_rdata !== 16'(exp_rdata)) $display("FAIL rnd_data%0d: got %h exp %h", i, mmio_rdata, 16'(exp_rdata)); else n_pass++;
            end
            n_checks++; if (ovf_irq !== model_irq()) $display("FAIL rnd_irq%0d: got %b exp %b", i, ovf_irq, model_irq()); else n_pass++;
        end
        events = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        events     = '0;
        mmio_req   = 1'b0;
        mmio_we    = 1'b0;
        mmio_addr  = '0;
        mmio_wdata = '0;
        model_reset();
        test_reset();
        test_cycle_mode();
        test_event_mode();
        test_overflow();
        test_write_vs_inc();
        test_global();
        test_decode();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
